// File: rtl/tomasulo_pkg.sv
// tomasulo_pkg: shared constants for the Tomasulo core slice.
//   LABEL_W / DATA_W : default result label and data widths
//   LABEL_NONE       : label value meaning "no dependency"; never broadcast
//   res_station_dst_e: station field of a label, {station[1:0], entry[1:0]}
package tomasulo_pkg;

    localparam int LABEL_W = 4;
    localparam int DATA_W  = 32;

    localparam logic [LABEL_W-1:0] LABEL_NONE = 4'h0;

    typedef enum logic [1:0] {
        STN_NONE = 2'b00,
        STN_ADD  = 2'b01,
        STN_MUL  = 2'b10,
        STN_LD   = 2'b11
    } res_station_dst_e;

endpackage

// File: rtl/cdb_arbiter_chk.sv
// cdb_arbiter_chk: simulation checker, reports reserved label 0 being handed
// over by an FU (such results are dropped by cdb_arbiter).
//   clk, nRST : clock and reset of the arbiter
//   fu_valid, fu_ready, fu_label : the FU handshake being observed
module cdb_arbiter_chk #(
    parameter int NUM_FU  = 3,
    parameter int LABEL_W = 4
) (
    input logic                        clk,
    input logic                        nRST,
    input logic [NUM_FU-1:0]           fu_valid,
    input logic [NUM_FU-1:0]           fu_ready,
    input logic [NUM_FU*LABEL_W-1:0]   fu_label
);

    // Any accepted transfer must carry a real producer label.
    always @(posedge clk) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (nRST && fu_valid[i] && fu_ready[i]) begin
                assert (fu_label[i*LABEL_W +: LABEL_W] != {LABEL_W{1'b0}})
                else $error("cdb_arbiter: FU%0d offered reserved label 0, result dropped", i);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: purely combinational round-robin pick.
//   req     : requesters
//   ptr     : index of the highest-priority requester
//   gnt     : one-hot grant (zero when nothing requests)
//   gnt_idx : binary index of the granted requester
//   any     : at least one requester present
module rr_arbiter #(
    parameter int N     = 3,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [PTR_W-1:0] gnt_idx,
    output logic             any
);

    logic [2*N-1:0] dbl_s;
    logic [N-1:0]   rot_s;
    logic [PTR_W-1:0] off_s;
    logic [PTR_W:0]   sum_s;

    // Rotate so ptr sits at bit 0, find the first set bit, then map back.
    always_comb begin
        dbl_s = {req, req} >> ptr;
        rot_s = dbl_s[N-1:0];
        off_s = {PTR_W{1'b0}};
        // Scan downwards so the lowest rotated position wins.
        for (int k = N - 1; k >= 0; k--) begin
            if (rot_s[k]) begin
                off_s = PTR_W'(k);
            end else begin
                off_s = off_s;
            end
        end
        sum_s = {1'b0, ptr} + {1'b0, off_s};
        if (sum_s >= (PTR_W+1)'(N)) begin
            sum_s = sum_s - (PTR_W+1)'(N);
        end else begin
            sum_s = sum_s;
        end
        gnt_idx = sum_s[PTR_W-1:0];
        any     = |req;
        if (any) begin
            gnt = N'(1) << gnt_idx;
        end else begin
            gnt = {N{1'b0}};
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the common data bus between the functional units.
// Each FU parks one result in its own holding slot via valid/ready; a
// round-robin arbiter drains one slot per cycle onto BCEN/BClabel/BCdata.
//   clk, nRST          : clock, asynchronous active-low reset
//   fu_valid/label/data: per-FU result offer (label/data packed by FU index)
//   fu_ready           : per-FU offer accepted this cycle
//   BCEN/BClabel/BCdata: broadcast to reservation stations and status table
//   bc_grant           : one-hot slot being drained this cycle
// Build options:
//   CDB_OUTREG_EN  : register BCEN/BClabel/BCdata (one extra cycle latency)
//   CDB_ARBITER_CHK: attach the reserved-label simulation checker
module cdb_arbiter #(
    parameter int NUM_FU  = 3,
    parameter int LABEL_W = tomasulo_pkg::LABEL_W,
    parameter int DATA_W  = tomasulo_pkg::DATA_W
) (
    input  logic                       clk,
    input  logic                       nRST,
    input  logic [NUM_FU-1:0]          fu_valid,
    input  logic [NUM_FU*LABEL_W-1:0]  fu_label,
    input  logic [NUM_FU*DATA_W-1:0]   fu_data,
    output logic [NUM_FU-1:0]          fu_ready,
    output logic                       BCEN,
    output logic [LABEL_W-1:0]         BClabel,
    output logic [DATA_W-1:0]          BCdata,
    output logic [NUM_FU-1:0]          bc_grant
);

    import tomasulo_pkg::*;

    localparam int PTR_W = $clog2(NUM_FU);

    logic [NUM_FU-1:0]  hold_valid_r;
    logic [LABEL_W-1:0] hold_label_r [NUM_FU];
    logic [DATA_W-1:0]  hold_data_r  [NUM_FU];
    logic [PTR_W-1:0]   rr_ptr_r;

    logic [NUM_FU-1:0]  gnt_s;
    logic [PTR_W-1:0]   gnt_idx_s;
    logic               any_s;
    logic [NUM_FU-1:0]  load_s;
    logic [PTR_W-1:0]   ptr_nxt_s;
    logic [LABEL_W-1:0] sel_label_s;
    logic [DATA_W-1:0]  sel_data_s;

    rr_arbiter #(
        .N     (NUM_FU),
        .PTR_W (PTR_W)
    ) u_rr (
        .req     (hold_valid_r),
        .ptr     (rr_ptr_r),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s),
        .any     (any_s)
    );

    // An occupied slot can only take new data in the cycle it drains.
    assign fu_ready = ~hold_valid_r | gnt_s;
    assign bc_grant = gnt_s;

    // Accepted offers are written only when they carry a real label;
    // a LABEL_NONE offer completes the handshake but is discarded.
    always_comb begin
        load_s = {NUM_FU{1'b0}};
        for (int i = 0; i < NUM_FU; i++) begin
            load_s[i] = fu_valid[i] & fu_ready[i]
                      & (fu_label[i*LABEL_W +: LABEL_W] != LABEL_W'(LABEL_NONE));
        end
    end

    // One-hot AND-OR select of the granted slot; zero when nothing is granted.
    always_comb begin
        sel_label_s = {LABEL_W{1'b0}};
        sel_data_s  = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_FU; i++) begin
            sel_label_s = sel_label_s | (hold_label_r[i] & {LABEL_W{gnt_s[i]}});
            sel_data_s  = sel_data_s  | (hold_data_r[i]  & {DATA_W{gnt_s[i]}});
        end
    end

    // Priority moves just past the winner; it holds when the bus is idle.
    always_comb begin
        if (!any_s) begin
            ptr_nxt_s = rr_ptr_r;
        end else if (gnt_idx_s == PTR_W'(NUM_FU - 1)) begin
            ptr_nxt_s = {PTR_W{1'b0}};
        end else begin
            ptr_nxt_s = gnt_idx_s + PTR_W'(1);
        end
    end

    // Holding slots and round-robin pointer.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            hold_valid_r <= {NUM_FU{1'b0}};
            rr_ptr_r     <= {PTR_W{1'b0}};
            for (int i = 0; i < NUM_FU; i++) begin
                hold_label_r[i] <= {LABEL_W{1'b0}};
                hold_data_r[i]  <= {DATA_W{1'b0}};
            end
        end else begin
            rr_ptr_r <= ptr_nxt_s;
            for (int i = 0; i < NUM_FU; i++) begin
                if (load_s[i]) begin
                    hold_valid_r[i] <= 1'b1;
                    hold_label_r[i] <= fu_label[i*LABEL_W +: LABEL_W];
                    hold_data_r[i]  <= fu_data[i*DATA_W +: DATA_W];
                end else if (gnt_s[i]) begin
                    hold_valid_r[i] <= 1'b0;
                end
            end
        end
    end

`ifdef CDB_OUTREG_EN
    logic               bcen_r;
    logic [LABEL_W-1:0] bclabel_r;
    logic [DATA_W-1:0]  bcdata_r;

    // Broadcast register, loaded with the winner at the edge that drains it.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            bcen_r    <= 1'b0;
            bclabel_r <= {LABEL_W{1'b0}};
            bcdata_r  <= {DATA_W{1'b0}};
        end else begin
            bcen_r    <= any_s;
            bclabel_r <= sel_label_s;
            bcdata_r  <= sel_data_s;
        end
    end

    assign BCEN    = bcen_r;
    assign BClabel = bclabel_r;
    assign BCdata  = bcdata_r;
`else
    assign BCEN    = any_s;
    assign BClabel = sel_label_s;
    assign BCdata  = sel_data_s;
`endif

`ifdef CDB_ARBITER_CHK
    cdb_arbiter_chk #(
        .NUM_FU  (NUM_FU),
        .LABEL_W (LABEL_W)
    ) u_chk (
        .clk      (clk),
        .nRST     (nRST),
        .fu_valid (fu_valid),
        .fu_ready (fu_ready),
        .fu_label (fu_label)
    );
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed self-checking bench for cdb_arbiter (NUM_FU=3,
// combinational broadcast build). Inputs change 1 time unit after the rising
// edge; outputs are checked at that point, once the slots have settled.
module tb_cdb_arbiter;

    logic        clk;
    logic        nRST;
    logic [2:0]  fu_valid;
    logic [11:0] fu_label;
    logic [95:0] fu_data;
    logic [2:0]  fu_ready;
    logic        BCEN;
    logic [3:0]  BClabel;
    logic [31:0] BCdata;
    logic [2:0]  bc_grant;

    int checks;
    int errors;

    cdb_arbiter #(
        .NUM_FU  (3),
        .LABEL_W (4),
        .DATA_W  (32)
    ) dut (
        .clk      (clk),
        .nRST     (nRST),
        .fu_valid (fu_valid),
        .fu_label (fu_label),
        .fu_data  (fu_data),
        .fu_ready (fu_ready),
        .BCEN     (BCEN),
        .BClabel  (BClabel),
        .BCdata   (BCdata),
        .bc_grant (bc_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input int i, input logic [3:0] lbl, input logic [31:0] dat);
        fu_label[i*4 +: 4]   = lbl;
        fu_data[i*32 +: 32]  = dat;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        nRST     = 1'b0;
        fu_valid = 3'b111;
        fu_label = 12'h000;
        fu_data  = 96'h0;
        offer(0, 4'h1, 32'h1111_0001);
        offer(1, 4'h2, 32'h2222_0002);
        offer(2, 4'h3, 32'h3333_0003);

        // Reset held for two cycles while all FUs offer.
        tick;
        tick;
        chk("rst_bcen",    BCEN,     32'd0);
        chk("rst_ready",   fu_ready, 32'h7);
        chk("rst_grant",   bc_grant, 32'h0);
        chk("rst_label",   BClabel,  32'h0);
        chk("rst_data",    BCdata,   32'h0);
        fu_valid = 3'b000;
        nRST     = 1'b1;
        tick;
        chk("rel_idle",    BCEN,     32'd0);

        // First grant after release goes to FU0, then 1, then 2.
        fu_valid = 3'b111;
        tick;
        fu_valid = 3'b000;
        chk("first_grant", bc_grant, 32'h1);
        chk("first_label", BClabel,  32'h1);
        chk("first_data",  BCdata,   32'h1111_0001);
        chk("first_ready", fu_ready, 32'h1);
        tick;
        chk("second_grant", bc_grant, 32'h2);
        chk("second_label", BClabel,  32'h2);
        chk("second_ready", fu_ready, 32'h3);
        tick;
        chk("third_grant", bc_grant, 32'h4);
        chk("third_label", BClabel,  32'h3);
        chk("third_ready", fu_ready, 32'h7);
        tick;
        chk("drain_idle",  BCEN,     32'd0);

        // Contention: all three FUs offer continuously, rr_ptr starts at 0.
        for (int i = 0; i < 3; i++) begin
            offer(i, 4'(4 + i), 32'hC000_0000 + 32'(i));
        end
        fu_valid = 3'b111;
        chk("cont_ready_pre", fu_ready, 32'h7);
        tick;
        for (int k = 0; k < 6; k++) begin
            chk("cont_bcen",  BCEN,     32'd1);
            chk("cont_label", BClabel,  32'(4 + (k % 3)));
            chk("cont_data",  BCdata,   32'hC000_0000 + 32'(k % 3));
            chk("cont_grant", bc_grant, 32'(1 << (k % 3)));
            chk("cont_ready", fu_ready, 32'(1 << (k % 3)));
            if (k == 5) begin
                fu_valid = 3'b000;
            end
            tick;
        end
        // FU0 and FU1 were refilled by their last grants; drain them.
        chk("cont_tail0", BClabel, 32'h4);
        tick;
        chk("cont_tail1", BClabel, 32'h5);
        tick;
        chk("cont_idle",  BCEN,    32'd0);

        // Single FU1 result is broadcast for exactly one cycle.
        offer(1, 4'h5, 32'hDEAD_BEEF);
        fu_valid = 3'b010;
        chk("single_ready", fu_ready, 32'h7);
        tick;
        fu_valid = 3'b000;
        chk("single_bcen",  BCEN,     32'd1);
        chk("single_label", BClabel,  32'h5);
        chk("single_data",  BCdata,   32'hDEAD_BEEF);
        chk("single_grant", bc_grant, 32'h2);
        tick;
        chk("single_once",  BCEN,     32'd0);
        chk("single_gnt0",  bc_grant, 32'h0);

        // Back-to-back stream from FU2: drain and refill at the same edge.
        offer(2, 4'h8, 32'h0000_0008);
        fu_valid = 3'b100;
        tick;
        chk("b2b_label8", BClabel,      32'h8);
        chk("b2b_ready8", fu_ready[2],  32'd1);
        chk("b2b_grant8", bc_grant,     32'h4);
        offer(2, 4'h9, 32'h0000_0009);
        tick;
        chk("b2b_label9", BClabel,      32'h9);
        chk("b2b_data9",  BCdata,       32'h9);
        chk("b2b_ready9", fu_ready[2],  32'd1);
        offer(2, 4'hA, 32'h0000_000A);
        tick;
        chk("b2b_labelA", BClabel,      32'hA);
        chk("b2b_readyA", fu_ready[2],  32'd1);
        fu_valid = 3'b000;
        tick;
        chk("b2b_idle",   BCEN,         32'd0);

        // Reserved label 0 from FU0 is accepted but never broadcast.
        offer(0, 4'h0, 32'hBAD0_0000);
        offer(1, 4'h7, 32'h0000_0007);
        fu_valid = 3'b011;
        chk("rsv_ready0", fu_ready[0], 32'd1);
        tick;
        fu_valid = 3'b000;
        chk("rsv_bcen",   BCEN,     32'd1);
        chk("rsv_label",  BClabel,  32'h7);
        chk("rsv_grant",  bc_grant, 32'h2);
        tick;
        chk("rsv_nolbl0", BCEN,     32'd0);
        chk("rsv_empty",  fu_ready, 32'h7);

        // Mid-operation reset with all slots full (rr_ptr is 2 here).
        offer(0, 4'hB, 32'h0000_000B);
        offer(1, 4'hC, 32'h0000_000C);
        offer(2, 4'hD, 32'h0000_000D);
        fu_valid = 3'b111;
        tick;
        fu_valid = 3'b000;
        chk("mr_pre_bcen",  BCEN,    32'd1);
        chk("mr_pre_label", BClabel, 32'hD);
        #2;
        nRST = 1'b0;
        #1;
        chk("mr_async_bcen",  BCEN,     32'd0);
        chk("mr_async_ready", fu_ready, 32'h7);
        chk("mr_async_grant", bc_grant, 32'h0);
        #2;
        nRST = 1'b1;
        tick;
        chk("mr_no_stale",   BCEN,    32'd0);
        chk("mr_no_label",   BClabel, 32'h0);
        // rr_ptr back at 0: with all three requesting, FU0 wins first.
        offer(0, 4'h1, 32'h0000_0001);
        offer(1, 4'h2, 32'h0000_0002);
        offer(2, 4'h3, 32'h0000_0003);
        fu_valid = 3'b111;
        tick;
        fu_valid = 3'b000;
        chk("mr_ptr0_grant", bc_grant, 32'h1);
        chk("mr_ptr0_label", BClabel,  32'h1);
        tick;
        tick;
        tick;
        chk("mr_final_idle", BCEN, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

- Shares the single common data bus (CDB) between the functional units of the Tomasulo core.
- Each FU hands over a finished result (producer label plus 32-bit value) through a valid/ready handshake. The block parks the result in a one-entry holding slot per FU.
- A round-robin arbiter picks one slot per cycle and drives it onto BCEN/BClabel/BCdata, which feed every reservation station and the register status table.

## Interface
Parameters:
- NUM_FU, default 3: number of requesting functional units, legal range 2..4.
- LABEL_W, default 4: label width, {station[1:0], entry[1:0]}.
- DATA_W, default 32: result data width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- fu_valid  in  NUM_FU  FU i offers a result.
- fu_label  in  NUM_FU*LABEL_W  label of FU i, slice [i*LABEL_W +: LABEL_W].
- fu_data  in  NUM_FU*DATA_W  result of FU i, slice [i*DATA_W +: DATA_W].
- fu_ready  out  NUM_FU  FU i's offer is accepted this cycle.
- BCEN  out  1  broadcast valid.
- BClabel  out  LABEL_W  broadcast label.
- BCdata  out  DATA_W  broadcast value.
- bc_grant  out  NUM_FU  one-hot indication of which FU's slot is being drained; zero when no slot is drained.

## Operation
- Per-FU slot state: hold_valid[i], hold_label[i], hold_data[i].
- Handshake:
  - fu_ready[i] = ~hold_valid[i] | bc_grant[i]. An occupied slot accepts new data only in the cycle it is drained.
  - A transfer occurs when fu_valid[i] and fu_ready[i] are both high at a rising edge. The slot then loads the offered label and data and sets hold_valid.
  - If a slot is drained with no new transfer, hold_valid clears.
- Arbitration:
  - Requesters are all i with hold_valid[i]=1.
  - rr_ptr holds the index of the highest-priority FU. The search order is rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_FU.
  - The first requester found is granted; bc_grant is one-hot for that FU.
  - On a grant to FU g, rr_ptr becomes (g+1) mod NUM_FU. With no grant, rr_ptr holds.
- Label 0 is reserved as "no dependency" and is never broadcast. An offer with fu_label=0 is still accepted by the handshake but is not written to the slot (it is dropped). Simulation raises an $error.
- Reset mid-operation clears all slots. Results held in the slots are lost. FUs must re-issue after reset.
- The block applies no back-pressure beyond fu_ready. An FU must keep fu_valid, fu_label and fu_data stable until it sees fu_ready.

## Timing
Reset values:
- fu_ready = all ones (slots empty).
- BCEN=0, BClabel=0, BCdata=0, bc_grant=0.
- rr_ptr=0; all hold_valid=0.

Latency and throughput:
- Base latency, without CDB_OUTREG_EN: a result accepted at edge N is broadcast during cycle N..N+1. BCEN is combinational from the slots, and the slot drains at edge N+1.
- One broadcast per cycle at most.
- A single busy FU sustains one result per cycle: its slot drains and refills at the same edge.

Boundary conditions:
- All slots full with no grant is impossible: some slot always wins.
- Simultaneous drain and refill of the same slot yields a new value next cycle with no bubble.
- With all NUM_FU slots requesting continuously, each FU is granted exactly once every NUM_FU cycles.

## Configuration
CDB_OUTREG_EN:
- Defined: BCEN, BClabel and BCdata are registered. The winning slot is loaded into the output register at the edge that drains it, so broadcast occurs one cycle later (accept at N, BCEN high during N+1..N+2). bc_grant stays combinational. The output register resets to 0, and BCEN drops the cycle after no grant.
- Undefined: the outputs are combinational from the granted slot, with zero added latency. This shortens the timing path budget to the reservation stations.

## Structure
- Package tomasulo_pkg:
  - LABEL_W, DATA_W.
  - LABEL_NONE = 4'h0.
  - Station IDs for the ResStationDst values (ADD=2'b01, MUL=2'b10, LD=2'b11).
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs: req[N-1:0], ptr.
  - Outputs: one-hot gnt, gnt_idx, any.
  - Purely combinational rotate/priority/unrotate.
  - rr_ptr and the slots live in cdb_arbiter.

## Test plan
- Reset: hold nRST low for 2 cycles with fu_valid=3'b111. Required: BCEN=0, fu_ready=3'b111, no slot loaded, and the first grant after release goes to FU0.
- Single FU: FU1 offers label 4'h5, data 32'hDEAD_BEEF. Required: the next cycle (or the cycle after, with CDB_OUTREG_EN) shows BCEN=1, BClabel=5, BCdata=DEADBEEF, bc_grant=3'b010, for exactly one cycle.
- Contention: FU0, FU1 and FU2 all offer labels 4,5,6 continuously with rr_ptr=0. Required: broadcast order 4,5,6,4,5,6, and fu_ready[i] is high only in FU i's grant cycle.
- Back-to-back: FU2 streams labels 8,9,10 on consecutive cycles with the other FUs idle. Required: three consecutive broadcasts 8,9,10 with no gap, and fu_ready[2] stays 1.
- Reserved label: FU0 offers label 0 while FU1 offers 4'h7. Required: fu_ready[0]=1, no broadcast of label 0, label 7 broadcast, and $error logged.
- Mid-operation reset: fill all three slots, then pulse nRST low mid-cycle. Required: BCEN drops immediately and asynchronously, no stale label is broadcast after release, and rr_ptr=0.
